bcd_countdown: RTL and testbench
================================

BCD_COUNTDOWN -- requirements
Module: bcd_countdown

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 1, meaning the number of tick rising edges per one-second decrement (legal range 1..65535).
REQ-002 The block SHALL have port clk_in  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port tick  input  1  periodic pulse from the upstream clock divider; only its rising edge is significant.
REQ-005 The block SHALL have port load  input  1  latch load_min/load_sec and go to IDLE.
REQ-006 The block SHALL have port load_min  input  8  preset minutes as two BCD digits, 00..99.
REQ-007 The block SHALL have port load_sec  input  8  preset seconds as two BCD digits, 00..59.
REQ-008 The block SHALL have port start  input  1  level request to begin or resume counting.
REQ-009 The block SHALL have port pause  input  1  level request to suspend counting.
REQ-010 The block SHALL have port min_out  output  8  current minutes, BCD.
REQ-011 The block SHALL have port sec_out  output  8  current seconds, BCD.
REQ-012 The block SHALL have port running  output  1  high while the state is RUN.
REQ-013 The block SHALL have port expired  output  1  high while the state is EXPIRED.
REQ-014 The block SHALL have port done  output  1  single-cycle pulse on entry to EXPIRED.

Function
REQ-015 The block SHALL register tick into tick_q each cycle; tick_rise SHALL equal tick AND NOT tick_q.
REQ-016 The block SHALL keep a sub-tick counter that advances only on tick_rise in RUN; reaching TICK_DIV SHALL produce one decrement and clear the counter.
REQ-017 The block SHALL use states IDLE, RUN, PAUSED and EXPIRED.
REQ-018 From IDLE, start with a nonzero count SHALL go to RUN; start at 00:00 SHALL be ignored.
REQ-019 From RUN, pause SHALL go to PAUSED and hold both the count and the sub-tick counter.
REQ-020 From PAUSED, start with pause low SHALL go to RUN; start together with pause SHALL stay PAUSED.
REQ-021 From RUN, a decrement that yields 00:00 SHALL go to EXPIRED and assert done for exactly one cycle.
REQ-022 In EXPIRED, start and pause SHALL be ignored; only load or rst SHALL leave the state.
REQ-023 Priority SHALL be load > pause > start > tick in every state.
REQ-024 Pause and tick_rise in the same RUN cycle SHALL result in PAUSED with no decrement.
REQ-025 load SHALL take effect in any state: latch the values, clear the sub-tick counter, enter IDLE and deassert done.
REQ-026 A decrement SHALL apply BCD borrow: sec units 0->9 with borrow; sec tens 0->5 with borrow; min units 0->9 with borrow; min tens decrements.
REQ-027 min_out and sec_out SHALL change on the same clk_in edge at which the qualifying tick_rise is sampled, i.e. one cycle after tick rises.
REQ-028 On load, an invalid BCD digit SHALL be clamped: any units digit >9 -> 9, sec tens >5 -> 5, min tens >9 -> 9.
REQ-029 When TICK_DIV=1, every tick_rise in RUN SHALL decrement the count.
REQ-030 In PAUSED, a tick_rise SHALL NOT advance the sub-tick counter.

Reset
REQ-031 Asserting rst SHALL immediately force IDLE, min_out=00, sec_out=00, sub-tick counter=0, running=0, expired=0 and done=0.
REQ-032 Asserting rst SHALL set tick_q=1, so a tick held high by the divider during reset does not produce a spurious tick_rise.
REQ-033 rst asserted mid-count SHALL discard the count; counting SHALL resume only after load and start.

Structure
REQ-034 Package timer_pkg SHALL hold the state encoding localparams, the BCD digit limits (9, 5) and the TICK_DIV counter width.
REQ-035 The block SHALL instantiate four copies of sub-module bcd_digit_dec (inputs: digit, borrow_in, max; outputs: next digit, borrow_out), chained for the borrow.

Verification
REQ-036 Load 00:03, start, TICK_DIV=1, 3 tick pulses -> sec_out 02, 01, 00; EXPIRED; done high for 1 cycle; expired held.
REQ-037 Load 01:00, run, 1 tick -> min_out=00, sec_out=59; 10 further ticks -> 00:49.
REQ-038 TICK_DIV=4, load 00:10, run, 8 ticks -> 00:08; pause after the 9th tick, 4 ticks -> still 00:08; resume, 3 ticks -> 00:07.
REQ-039 Tick held high 5 cycles -> exactly one decrement; tick high during and after rst release -> no decrement.
REQ-040 pause and tick_rise in the same cycle -> PAUSED, count unchanged; load and start in the same cycle -> IDLE with the loaded value.
REQ-041 load_sec=8'h7C -> sec_out=59; start at 00:00 -> stays IDLE; rst at 00:30 in RUN -> 00:00, IDLE.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the BCD countdown timer: state encoding, BCD digit
// limits, sub-tick counter width and the load-time digit clamp.
package timer_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_PAUSED  = 2'd2;
  localparam logic [1:0] ST_EXPIRED = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    RUN     = ST_RUN,
    PAUSED  = ST_PAUSED,
    EXPIRED = ST_EXPIRED
  } state_t;

  localparam logic [3:0] BCD_UNITS_MAX    = 4'd9;
  localparam logic [3:0] BCD_SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] BCD_MIN_TENS_MAX = 4'd9;

  // Wide enough for the largest legal TICK_DIV (65535).
  localparam int TICK_CNT_W = 16;

  // Clamp a two-digit BCD byte so each digit stays within its legal range.
  function automatic logic [7:0] clamp_bcd(input logic [7:0] value,
                                           input logic [3:0] tens_max);
    logic [3:0] tens;
    logic [3:0] units;
    tens  = (value[7:4] > tens_max)      ? tens_max      : value[7:4];
    units = (value[3:0] > BCD_UNITS_MAX) ? BCD_UNITS_MAX : value[3:0];
    return {tens, units};
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of the countdown borrow chain: decrements when borrow_in is
// set and wraps 0 -> max with borrow_out.
module bcd_digit_dec (
  input  logic [3:0] digit,
  input  logic       borrow_in,
  input  logic [3:0] max,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = max;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// MM:SS BCD countdown timer with load/start/pause control, a tick prescaler
// of TICK_DIV tick rising edges per second, and a one-cycle done pulse.
module bcd_countdown
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_out,
  output logic [7:0] sec_out,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam logic [TICK_CNT_W-1:0] SUB_LAST = TICK_CNT_W'(TICK_DIV - 1);

  state_t                state;
  logic                  tick_q;
  logic                  tick_rise;
  logic [TICK_CNT_W-1:0] sub_cnt;
  logic [15:0]           dec_val;
  logic [3:0]            borrow;
  logic                  count_nonzero;

  assign tick_rise     = tick & ~tick_q;
  assign count_nonzero = (min_out != 8'h00) || (sec_out != 8'h00);

  // Borrow chain, least significant digit first; the seconds-units digit always decrements.
  bcd_digit_dec u_sec_units (
    .digit(sec_out[3:0]), .borrow_in(1'b1), .max(BCD_UNITS_MAX),
    .digit_next(dec_val[3:0]), .borrow_out(borrow[0])
  );
  bcd_digit_dec u_sec_tens (
    .digit(sec_out[7:4]), .borrow_in(borrow[0]), .max(BCD_SEC_TENS_MAX),
    .digit_next(dec_val[7:4]), .borrow_out(borrow[1])
  );
  bcd_digit_dec u_min_units (
    .digit(min_out[3:0]), .borrow_in(borrow[1]), .max(BCD_UNITS_MAX),
    .digit_next(dec_val[11:8]), .borrow_out(borrow[2])
  );
  bcd_digit_dec u_min_tens (
    .digit(min_out[7:4]), .borrow_in(borrow[2]), .max(BCD_MIN_TENS_MAX),
    .digit_next(dec_val[15:12]), .borrow_out(borrow[3])
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tick_q  <= 1'b1;   // a tick held high through reset must not look like a fresh edge
      sub_cnt <= '0;
      min_out <= 8'h00;
      sec_out <= 8'h00;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      tick_q <= tick;
      done   <= 1'b0;
      if (load) begin
        min_out <= clamp_bcd(load_min, BCD_MIN_TENS_MAX);
        sec_out <= clamp_bcd(load_sec, BCD_SEC_TENS_MAX);
        sub_cnt <= '0;
        state   <= IDLE;
        running <= 1'b0;
        expired <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!pause && start && count_nonzero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          RUN: begin
            if (pause) begin
              state   <= PAUSED;
              running <= 1'b0;
            end else if (tick_rise) begin
              if (sub_cnt == SUB_LAST) begin
                sub_cnt <= '0;
                // A full-chain borrow means 00:00; never wrap to 99:59.
                if (!borrow[3]) begin
                  min_out <= dec_val[15:8];
                  sec_out <= dec_val[7:0];
                  if (dec_val == 16'h0000) begin
                    state   <= EXPIRED;
                    running <= 1'b0;
                    expired <= 1'b1;
                    done    <= 1'b1;
                  end
                end
              end else begin
                sub_cnt <= sub_cnt + 1'b1;
              end
            end
          end
          PAUSED: begin
            if (start && !pause) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
          end
          default: begin
            state   <= IDLE;
            running <= 1'b0;
            expired <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_countdown.sv
// Self-checking bench: two timers (TICK_DIV 1 and 4) share stimulus and are
// compared every cycle against a seconds-based reference model.
module tb_bcd_countdown;

  localparam int DIV_A = 1;
  localparam int DIV_B = 4;

  typedef enum int {M_IDLE, M_RUN, M_PAUSED, M_EXPIRED} mstate_t;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic [7:0] min_o [2];
  logic [7:0] sec_o [2];
  logic       run_o [2];
  logic       exp_o [2];
  logic       done_o[2];

  int checks = 0;
  int errors = 0;

  // Reference model: total remaining seconds per instance.
  int      m_secs[2];
  int      m_sub [2];
  mstate_t m_st  [2];
  logic    m_done[2];
  logic    m_tq;

  always #5 clk_in = ~clk_in;

  bcd_countdown #(.TICK_DIV(DIV_A)) u_dut_a (
    .clk_in(clk_in), .rst(rst), .tick(tick), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .min_out(min_o[0]), .sec_out(sec_o[0]), .running(run_o[0]),
    .expired(exp_o[0]), .done(done_o[0])
  );

  bcd_countdown #(.TICK_DIV(DIV_B)) u_dut_b (
    .clk_in(clk_in), .rst(rst), .tick(tick), .load(load),
    .load_min(load_min), .load_sec(load_sec), .start(start), .pause(pause),
    .min_out(min_o[1]), .sec_out(sec_o[1]), .running(run_o[1]),
    .expired(exp_o[1]), .done(done_o[1])
  );

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int clamp_secs(input logic [7:0] m, input logic [7:0] s);
    int mt = int'(m[7:4]);
    int mu = int'(m[3:0]);
    int st = int'(s[7:4]);
    int su = int'(s[3:0]);
    if (mt > 9) mt = 9;
    if (mu > 9) mu = 9;
    if (st > 5) st = 5;
    if (su > 9) su = 9;
    return (mt * 10 + mu) * 60 + st * 10 + su;
  endfunction

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    m_tq = 1'b1;
    for (int k = 0; k < 2; k++) begin
      m_secs[k] = 0;
      m_sub[k]  = 0;
      m_st[k]   = M_IDLE;
      m_done[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic rise;
    int   div;
    rise = tick && !m_tq;
    m_tq = tick;
    for (int k = 0; k < 2; k++) begin
      div       = (k == 0) ? DIV_A : DIV_B;
      m_done[k] = 1'b0;
      if (load) begin
        m_secs[k] = clamp_secs(load_min, load_sec);
        m_sub[k]  = 0;
        m_st[k]   = M_IDLE;
      end else begin
        case (m_st[k])
          M_IDLE:   if (!pause && start && m_secs[k] != 0) m_st[k] = M_RUN;
          M_RUN: begin
            if (pause) m_st[k] = M_PAUSED;
            else if (rise) begin
              m_sub[k]++;
              if (m_sub[k] == div) begin
                m_sub[k] = 0;
                m_secs[k]--;
                if (m_secs[k] == 0) begin
                  m_st[k]   = M_EXPIRED;
                  m_done[k] = 1'b1;
                end
              end
            end
          end
          M_PAUSED: if (start && !pause) m_st[k] = M_RUN;
          default: ;
        endcase
      end
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("min_out[%0d]", k), min_o[k], to_bcd(m_secs[k] / 60));
      check($sformatf("sec_out[%0d]", k), sec_o[k], to_bcd(m_secs[k] % 60));
      check($sformatf("running[%0d]", k), {7'd0, run_o[k]}, {7'd0, m_st[k] == M_RUN});
      check($sformatf("expired[%0d]", k), {7'd0, exp_o[k]}, {7'd0, m_st[k] == M_EXPIRED});
      check($sformatf("done[%0d]", k), {7'd0, done_o[k]}, {7'd0, m_done[k]});
    end
  endtask

  // One clock cycle with the current inputs; outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_in);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tick_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      step();
    end
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; load_min = m; load_sec = s;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Asserts rst between edges so the asynchronous clear is observed before any clock.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk_in);
    #1;
    compare_all();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; load_min = 8'h00; load_sec = 8'h00;
    start = 1'b0; pause = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clk_in);
    #1;
    rst = 1'b0;
    check("reset_min", min_o[0], 8'h00);
    check("reset_running", {7'd0, run_o[0]}, 8'h00);

    // 00:03 counts down to expiry with TICK_DIV=1.
    do_load(8'h00, 8'h03);
    do_start();
    tick_pulses(3);
    check("expire_sec", sec_o[0], 8'h00);
    check("expire_held", {7'd0, exp_o[0]}, 8'h01);
    steps(2);

    // Minute borrow: 01:00 -> 00:59 -> 00:49.
    do_load(8'h01, 8'h00);
    do_start();
    tick_pulses(1);
    check("borrow_min", min_o[0], 8'h00);
    check("borrow_sec", sec_o[0], 8'h59);
    tick_pulses(10);
    check("after10_sec", sec_o[0], 8'h49);

    // Prescaler and pause on the TICK_DIV=4 instance.
    do_load(8'h00, 8'h10);
    do_start();
    tick_pulses(8);
    check("div4_8ticks", sec_o[1], 8'h08);
    tick_pulses(1);
    pause = 1'b1;
    tick_pulses(4);
    check("div4_paused_sec", sec_o[1], 8'h08);
    check("div4_paused_run", {7'd0, run_o[1]}, 8'h00);
    pause = 1'b0;
    do_start();
    tick_pulses(3);
    check("div4_resumed", sec_o[1], 8'h07);

    // Tick held high counts once; tick high across reset release counts never.
    do_load(8'h00, 8'h20);
    do_start();
    tick = 1'b1;
    steps(5);
    tick = 1'b0;
    step();
    check("held_tick", sec_o[0], 8'h19);
    tick = 1'b1;
    do_reset();
    do_load(8'h00, 8'h20);
    do_start();
    steps(3);
    check("tick_through_rst", sec_o[0], 8'h20);
    check("tick_through_rst_run", {7'd0, run_o[0]}, 8'h01);
    tick = 1'b0;
    step();

    // Pause beats a simultaneous tick; load beats a simultaneous start.
    pause = 1'b1; tick = 1'b1;
    step();
    check("pause_tick_sec", sec_o[0], 8'h20);
    check("pause_tick_run", {7'd0, run_o[0]}, 8'h00);
    pause = 1'b0; tick = 1'b0;
    start = 1'b1;
    do_load(8'h00, 8'h45);
    start = 1'b0;
    check("load_start_sec", sec_o[0], 8'h45);
    check("load_start_run", {7'd0, run_o[0]}, 8'h00);

    // Clamping, start at zero ignored, reset mid-count.
    do_load(8'h00, 8'h7C);
    check("clamp_sec", sec_o[0], 8'h59);
    do_load(8'hAF, 8'h3F);
    check("clamp_min", min_o[0], 8'h99);
    check("clamp_sec2", sec_o[0], 8'h39);
    do_load(8'h00, 8'h00);
    do_start();
    check("zero_start", {7'd0, run_o[0]}, 8'h00);
    do_load(8'h00, 8'h30);
    do_start();
    tick_pulses(1);
    do_reset();
    check("rst_mid_sec", sec_o[0], 8'h00);
    do_start();
    check("rst_mid_idle", {7'd0, run_o[0]}, 8'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      load = ($urandom_range(0, 39) == 0);
      if (load) begin
        load_min = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
        load_sec = 8'($urandom);
      end
      start = ($urandom_range(0, 2) == 0);
      pause = ($urandom_range(0, 9) == 0);
      tick  = ($urandom_range(0, 1) == 0);
      step();
    end
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
